// File: rtl/fp_mul_controller.sv
// fp_mul_controller: sequencer for a registered floating-point multiplier
// datapath. Accepts operand pairs over valid/ready, steps the datapath
// through LOAD (operand register write) and COMPUTE (output register write),
// then holds the captured product and exception flags in RESULT until the
// downstream side accepts them.
//
// Optional feature: define FP_MUL_EXC_COUNT_EN to add overflow_count and
// nan_count outputs, which count delivered results carrying each exception.
module fp_mul_controller #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic [WIDTH-1:0]       dp_a,
    output logic [WIDTH-1:0]       dp_b,
    output logic                   dp_write_enable_a,
    output logic                   dp_write_enable_b,
    output logic                   dp_read_enable_a,
    output logic                   dp_read_enable_b,
    output logic                   dp_write_enable_out,
    output logic                   dp_read_enable_out,
    output logic                   dp_reset,
    input  logic [WIDTH-1:0]       dp_product,
    input  logic                   dp_overflow,
    input  logic                   dp_nan,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_product,
    output logic                   out_overflow,
    output logic                   out_nan,
`ifdef FP_MUL_EXC_COUNT_EN
    output logic [COUNT_WIDTH-1:0] overflow_count,
    output logic [COUNT_WIDTH-1:0] nan_count,
`endif
    output logic [COUNT_WIDTH-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        RESULT  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       a_q, b_q;
    logic                   we_ab_q;
    logic                   re_ab_q;
    logic                   we_out_q;
    logic                   re_out_q;
    logic                   out_valid_q;
    logic                   ovf_q, nan_q;
    logic [COUNT_WIDTH-1:0] op_count_q;
`ifdef FP_MUL_EXC_COUNT_EN
    logic [COUNT_WIDTH-1:0] ovf_count_q, nan_count_q;
`endif

    logic accept_d;
    logic handshake_d;

    // Handshake decode; clear/reset block any accept in the same cycle.
    always_comb begin
        in_ready    = 1'b0;
        handshake_d = 1'b0;
        if (!reset && !clear) begin
            in_ready    = (state_q == IDLE) || ((state_q == RESULT) && out_ready);
            handshake_d = (state_q == RESULT) && out_ready;
        end
        accept_d = in_ready && in_valid;
    end

    // Sequencer: state, registered enables, captured flags and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            we_ab_q     <= 1'b0;
            re_ab_q     <= 1'b0;
            we_out_q    <= 1'b0;
            re_out_q    <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            nan_q       <= 1'b0;
            op_count_q  <= '0;
`ifdef FP_MUL_EXC_COUNT_EN
            ovf_count_q <= '0;
            nan_count_q <= '0;
`endif
        end else if (clear) begin
            // Flush the in-flight operation but keep all counters.
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            we_ab_q     <= 1'b0;
            re_ab_q     <= 1'b0;
            we_out_q    <= 1'b0;
            re_out_q    <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            nan_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        we_ab_q <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    we_ab_q  <= 1'b0;
                    re_ab_q  <= 1'b1;
                    we_out_q <= 1'b1;
                    state_q  <= COMPUTE;
                end
                COMPUTE: begin
                    // Flags come from the operand registers, so they are valid
                    // on the same edge the output register takes the product.
                    re_ab_q     <= 1'b0;
                    we_out_q    <= 1'b0;
                    ovf_q       <= dp_overflow;
                    nan_q       <= dp_nan;
                    out_valid_q <= 1'b1;
                    re_out_q    <= 1'b1;
                    state_q     <= RESULT;
                end
                RESULT: begin
                    if (handshake_d) begin
                        op_count_q  <= op_count_q + COUNT_WIDTH'(1);
`ifdef FP_MUL_EXC_COUNT_EN
                        if (ovf_q) ovf_count_q <= ovf_count_q + COUNT_WIDTH'(1);
                        if (nan_q) nan_count_q <= nan_count_q + COUNT_WIDTH'(1);
`endif
                        out_valid_q <= 1'b0;
                        re_out_q    <= 1'b0;
                        if (accept_d) begin
                            a_q     <= in_a;
                            b_q     <= in_b;
                            we_ab_q <= 1'b1;
                            state_q <= LOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dp_a                = a_q;
    assign dp_b                = b_q;
    assign dp_write_enable_a   = we_ab_q;
    assign dp_write_enable_b   = we_ab_q;
    assign dp_read_enable_a    = re_ab_q;
    assign dp_read_enable_b    = re_ab_q;
    assign dp_write_enable_out = we_out_q;
    assign dp_read_enable_out  = re_out_q;
    assign dp_reset            = reset | clear;
    assign out_valid           = out_valid_q;
    assign out_product         = out_valid_q ? dp_product : '0;
    assign out_overflow        = ovf_q;
    assign out_nan             = nan_q;
    assign op_count            = op_count_q;
`ifdef FP_MUL_EXC_COUNT_EN
    assign overflow_count      = ovf_count_q;
    assign nan_count           = nan_count_q;
`endif

endmodule

// File: tb/tb_fp_mul_controller.sv
// Directed bench for fp_mul_controller with a small behavioural model of the
// registered multiplier datapath (operand registers, product table, output
// register).
module tb_fp_mul_controller;

    localparam int WIDTH = 32;
    localparam int CW    = 16;

    logic             clk = 1'b0;
    logic             reset, clear, in_valid, in_ready, out_ready;
    logic [WIDTH-1:0] in_a, in_b, dp_a, dp_b, dp_product, out_product;
    logic             dp_write_enable_a, dp_write_enable_b;
    logic             dp_read_enable_a, dp_read_enable_b;
    logic             dp_write_enable_out, dp_read_enable_out, dp_reset;
    logic             dp_overflow, dp_nan, out_valid, out_overflow, out_nan;
    logic [CW-1:0]    op_count;
`ifdef FP_MUL_EXC_COUNT_EN
    logic [CW-1:0]    overflow_count, nan_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_mul_controller #(.WIDTH(WIDTH), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dp_a(dp_a), .dp_b(dp_b),
        .dp_write_enable_a(dp_write_enable_a), .dp_write_enable_b(dp_write_enable_b),
        .dp_read_enable_a(dp_read_enable_a), .dp_read_enable_b(dp_read_enable_b),
        .dp_write_enable_out(dp_write_enable_out), .dp_read_enable_out(dp_read_enable_out),
        .dp_reset(dp_reset), .dp_product(dp_product),
        .dp_overflow(dp_overflow), .dp_nan(dp_nan),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .out_overflow(out_overflow), .out_nan(out_nan),
`ifdef FP_MUL_EXC_COUNT_EN
        .overflow_count(overflow_count), .nan_count(nan_count),
`endif
        .op_count(op_count)
    );

    // Hand-computed IEEE-754 single-precision products for the vectors used.
    function automatic logic [33:0] mul_lut(input logic [31:0] a, input logic [31:0] b);
        // {overflow, nan, product}
        if (a == 32'h40000000 && b == 32'h40400000) return {2'b00, 32'h40C00000};
        if (a == 32'h3F800000 && b == 32'h3F800000) return {2'b00, 32'h3F800000};
        if (a == 32'h40000000 && b == 32'h40000000) return {2'b00, 32'h40800000};
        if (a == 32'h3FC00000 && b == 32'h40000000) return {2'b00, 32'h40400000};
        if (a == 32'h40400000 && b == 32'h40400000) return {2'b00, 32'h41100000};
        if (a == 32'h7F800000 && b == 32'h00000000) return {2'b01, 32'h7FC00000};
        if (a == 32'h7F7FFFFF && b == 32'h40000000) return {2'b10, 32'h7F800000};
        return 34'd0;
    endfunction

    logic [31:0] reg_a, reg_b, reg_out;
    logic [33:0] lut_now;
    assign lut_now     = mul_lut(reg_a, reg_b);
    assign dp_overflow = lut_now[33];
    assign dp_nan      = lut_now[32];
    assign dp_product  = reg_out;

    always_ff @(posedge clk) begin
        if (dp_reset) begin
            reg_a   <= '0;
            reg_b   <= '0;
            reg_out <= '0;
        end else begin
            if (dp_write_enable_a)   reg_a   <= dp_a;
            if (dp_write_enable_b)   reg_b   <= dp_b;
            if (dp_write_enable_out) reg_out <= lut_now[31:0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one pair from IDLE and advance to RESULT.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic [31:0] pp [4];

    initial begin
        pa[0] = 32'h3F800000; pb[0] = 32'h3F800000; pp[0] = 32'h3F800000;
        pa[1] = 32'h40000000; pb[1] = 32'h40000000; pp[1] = 32'h40800000;
        pa[2] = 32'h3FC00000; pb[2] = 32'h40000000; pp[2] = 32'h40400000;
        pa[3] = 32'h40400000; pb[3] = 32'h40400000; pp[3] = 32'h41100000;

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0;
        tick();
        tick();
        chk("rst_dp_reset", dp_reset, 1);
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_in_ready_idle", in_ready, 1);
        chk("rst_enables", {dp_write_enable_a, dp_write_enable_b, dp_read_enable_a,
            dp_read_enable_b, dp_write_enable_out, dp_read_enable_out}, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_flags", {out_overflow, out_nan}, 0);
        chk("rst_out_product", out_product, 0);
        chk("rst_dp_reset_low", dp_reset, 0);

        // Single operation 2.0 * 3.0
        out_ready = 1'b1;
        in_a = 32'h40000000; in_b = 32'h40400000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("op1_load_in_ready", in_ready, 0);
        chk("op1_load_we_ab", {dp_write_enable_a, dp_write_enable_b}, 2'b11);
        chk("op1_load_we_out", dp_write_enable_out, 0);
        chk("op1_load_dp_a", dp_a, 32'h40000000);
        chk("op1_load_dp_b", dp_b, 32'h40400000);
        tick();
        chk("op1_comp_in_ready", in_ready, 0);
        chk("op1_comp_re_ab", {dp_read_enable_a, dp_read_enable_b}, 2'b11);
        chk("op1_comp_we", {dp_write_enable_out, dp_write_enable_a}, 2'b10);
        chk("op1_comp_out_valid", out_valid, 0);
        tick();
        chk("op1_res_out_valid", out_valid, 1);
        chk("op1_res_product", out_product, 32'h40C00000);
        chk("op1_res_flags", {out_overflow, out_nan}, 0);
        chk("op1_res_re_out", dp_read_enable_out, 1);
        chk("op1_res_in_ready", in_ready, 1);
        tick();
        chk("op1_done_out_valid", out_valid, 0);
        chk("op1_done_op_count", op_count, 1);
        chk("op1_done_product_zero", out_product, 0);

        // Backpressure
        out_ready = 1'b0;
        run_op(32'h40000000, 32'h40400000);
        in_a = 32'h3F800000; in_b = 32'h3F800000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_product", out_product, 32'h40C00000);
            chk("bp_in_ready", in_ready, 0);
            tick();
            chk("bp_dp_a_held", dp_a, 32'h40000000);
            chk("bp_op_count", op_count, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        tick();
        chk("bp_done_out_valid", out_valid, 0);
        chk("bp_done_idle_in_ready", in_ready, 1);
        chk("bp_done_op_count", op_count, 2);

        // Back-to-back with in_valid held high
        in_a = pa[0]; in_b = pb[0]; in_valid = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            chk("b2b_out_valid", out_valid, 1);
            chk("b2b_product", out_product, pp[k]);
            chk("b2b_in_ready", in_ready, 1);
            if (k < 3) begin
                in_a = pa[k+1]; in_b = pb[k+1];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (k < 3) begin
                chk("b2b_reload_we_a", dp_write_enable_a, 1);
                chk("b2b_reload_dp_a", dp_a, pa[k+1]);
                chk("b2b_reload_in_ready", in_ready, 0);
            end
        end
        chk("b2b_done_out_valid", out_valid, 0);
        chk("b2b_op_count", op_count, 6);

        // Exceptions
        run_op(32'h7F800000, 32'h00000000);
        chk("exc_nan_valid", out_valid, 1);
        chk("exc_nan_product", out_product, 32'h7FC00000);
        chk("exc_nan_flags", {out_overflow, out_nan}, 2'b01);
        tick();
        run_op(32'h7F7FFFFF, 32'h40000000);
        chk("exc_ovf_valid", out_valid, 1);
        chk("exc_ovf_product", out_product, 32'h7F800000);
        chk("exc_ovf_flags", {out_overflow, out_nan}, 2'b10);
        tick();
        chk("exc_op_count", op_count, 8);
`ifdef FP_MUL_EXC_COUNT_EN
        chk("exc_nan_count", nan_count, 1);
        chk("exc_overflow_count", overflow_count, 1);
`endif

        // clear during COMPUTE
        in_a = 32'h40000000; in_b = 32'h40400000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("clr_in_compute", dp_write_enable_out, 1);
        clear = 1'b1;
        #1;
        chk("clr_dp_reset", dp_reset, 1);
        tick();
        clear = 1'b0;
        #1;
        chk("clr_out_valid", out_valid, 0);
        chk("clr_enables", {dp_write_enable_a, dp_read_enable_a, dp_write_enable_out,
            dp_read_enable_out}, 0);
        chk("clr_op_count", op_count, 8);
        chk("clr_idle_in_ready", in_ready, 1);
        tick();
        chk("clr_no_result", out_valid, 0);
        tick();
        chk("clr_no_result2", out_valid, 0);
`ifdef FP_MUL_EXC_COUNT_EN
        chk("clr_nan_count_kept", nan_count, 1);
        chk("clr_ovf_count_kept", overflow_count, 1);
`endif
        // clear in IDLE blocks an accept
        clear = 1'b1; in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000;
        #1;
        chk("clr_idle_in_ready_forced", in_ready, 0);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_idle_not_accepted", dp_write_enable_a, 0);
        tick();
        chk("clr_idle_still_idle", {dp_read_enable_a, dp_write_enable_out}, 0);
        // following operation completes normally
        run_op(32'h3FC00000, 32'h40000000);
        chk("after_clr_valid", out_valid, 1);
        chk("after_clr_product", out_product, 32'h40400000);
        tick();
        chk("after_clr_op_count", op_count, 9);

        // reset during RESULT
        out_ready = 1'b0;
        run_op(32'h7F800000, 32'h00000000);
        chk("rstres_valid", out_valid, 1);
        chk("rstres_nan", out_nan, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rstres_out_valid", out_valid, 0);
        chk("rstres_op_count", op_count, 0);
        chk("rstres_flags", {out_overflow, out_nan}, 0);
`ifdef FP_MUL_EXC_COUNT_EN
        chk("rstres_nan_count", nan_count, 0);
        chk("rstres_ovf_count", overflow_count, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
